timepulse_multi: RTL and testbench

//  Parametrised time base: a prescaler divides clk_i into a base tick tp_o every
//  MAX_COUNT = PULSE_PER_NS/CLK_PER_NS cycles. NCH independent channel dividers

---
 rtl/timepulse_multi_pkg.sv | 17 +
 rtl/timepulse_ch.sv | 47 ++++
 rtl/timepulse_multi.sv | 69 ++++++
 tb/tb_timepulse_multi.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/timepulse_multi_pkg.sv
// Shared sizing helpers for the timepulse time base and its users.
package timepulse_multi_pkg;

    // Base tick length in clock cycles.
    function automatic int calc_max_count(input int clk_per_ns, input int pulse_per_ns);
        return pulse_per_ns / clk_per_ns;
    endfunction

    function automatic int idx_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/timepulse_ch.sv
// One channel divider: counts base ticks and emits a pulse every per-th tick.
module timepulse_ch
    import timepulse_multi_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync,
    input  logic             wr,
    input  logic             wrap,
    input  logic [DIV_W-1:0] wr_data,
    output logic             pulse
);

    logic [DIV_W-1:0] per;
    logic [DIV_W-1:0] cnt;

    // A write wins over the tick in the same cycle, so a pending pulse is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            per   <= '0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (wr) begin
                per <= wr_data;
                cnt <= '0;
            end else if (sync) begin
                cnt <= '0;
            end else if (wrap && (per != '0)) begin
                if (cnt == per - DIV_W'(1)) begin
                    cnt   <= '0;
                    pulse <= 1'b1;
                end else begin
                    cnt <= cnt + DIV_W'(1);
                end
            end
        end
    end

    a_pulse_width: assert property (@(posedge clk) disable iff (rst) pulse |=> !pulse);
    a_cnt_range:   assert property (@(posedge clk) disable iff (rst) (per != '0) |-> (cnt < per));
    c_pulse:       cover property (@(posedge clk) pulse);

endmodule

// File: rtl/timepulse_multi.sv
// Prescaled base tick plus NCH programmable channel dividers of that tick.
module timepulse_multi
    import timepulse_multi_pkg::*;
#(
    parameter int CLK_PER_NS   = 40,
    parameter int PULSE_PER_NS = 5120,
    parameter int NCH          = 4,
    parameter int DIV_W        = 16,
    localparam int CH_W        = idx_width(NCH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [CH_W-1:0]  wr_ch_i,
    input  logic [DIV_W-1:0] wr_data_i,
    output logic             tp_o,
    output logic [NCH-1:0]   ch_tp_o
);

    localparam int MAX_COUNT = calc_max_count(CLK_PER_NS, PULSE_PER_NS);
    localparam int PRE_W     = cnt_width(MAX_COUNT);

    generate
        if (MAX_COUNT < 2) begin : g_bad_max_count
            $error("timepulse_multi: MAX_COUNT must be at least 2");
        end
        if ((NCH < 1) || (NCH > 16)) begin : g_bad_nch
            $error("timepulse_multi: NCH must be within 1..16");
        end
    endgenerate

    logic [PRE_W-1:0] pre_cnt;
    logic             wrap;
    logic [NCH-1:0]   wr_sel;

    assign wrap = (pre_cnt == PRE_W'(MAX_COUNT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || sync_i) begin
            pre_cnt <= '0;
            tp_o    <= 1'b0;
        end else begin
            tp_o    <= wrap;
            pre_cnt <= wrap ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    // Out-of-range channel indices match no channel and are dropped here.
    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign wr_sel[c] = wr_i && (wr_ch_i == CH_W'(c));

        timepulse_ch #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk     (clk_i),
            .rst     (rst_i),
            .sync    (sync_i),
            .wr      (wr_sel[c]),
            .wrap    (wrap),
            .wr_data (wr_data_i),
            .pulse   (ch_tp_o[c])
        );
    end

    a_tp_width:   assert property (@(posedge clk_i) disable iff (rst_i) tp_o |=> !tp_o);
    a_ch_with_tp: assert property (@(posedge clk_i) disable iff (rst_i) (|ch_tp_o) |-> tp_o);

endmodule

// File: tb/tb_timepulse_multi.sv
// Bench for timepulse_multi: directed scenarios with literal expectations plus randomized traffic.
module tb_timepulse_multi;

    localparam int NCH   = 5;
    localparam int DIV_W = 16;
    localparam int CH_W  = 3;
    localparam int M     = 10;

    logic             clk_i     = 1'b0;
    logic             rst_i     = 1'b1;
    logic             sync_i    = 1'b0;
    logic             wr_i      = 1'b0;
    logic [CH_W-1:0]  wr_ch_i   = '0;
    logic [DIV_W-1:0] wr_data_i = '0;
    logic             tp_o;
    logic [NCH-1:0]   ch_tp_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    timepulse_multi #(
        .CLK_PER_NS   (40),
        .PULSE_PER_NS (400),
        .NCH          (NCH),
        .DIV_W        (DIV_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .sync_i    (sync_i),
        .wr_i      (wr_i),
        .wr_ch_i   (wr_ch_i),
        .wr_data_i (wr_data_i),
        .tp_o      (tp_o),
        .ch_tp_o   (ch_tp_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: cycles since last phase anchor, and base ticks since each channel's anchor.
    int             e_cyc;
    int             per_m [NCH];
    int             k_tick[NCH];
    bit             tick_m;
    bit             exp_tp   = 1'b0;
    logic [NCH-1:0] exp_ch   = '0;
    bit             model_ok = 1'b0;

    initial forever begin
        @(posedge clk_i);
        if (rst_i) begin
            e_cyc  = 0;
            exp_tp = 1'b0;
            exp_ch = '0;
            for (int c = 0; c < NCH; c++) begin
                per_m[c]  = 0;
                k_tick[c] = 0;
            end
            model_ok = 1'b1;
        end else begin
            tick_m = 1'b0;
            if (sync_i) begin
                e_cyc = 0;
            end else begin
                e_cyc++;
                tick_m = ((e_cyc % M) == 0);
            end
            exp_tp = tick_m;
            for (int c = 0; c < NCH; c++) begin
                exp_ch[c] = 1'b0;
                if (wr_i && (int'(wr_ch_i) == c)) begin
                    per_m[c]  = int'(wr_data_i);
                    k_tick[c] = 0;
                end else if (sync_i) begin
                    k_tick[c] = 0;
                end else if (tick_m) begin
                    k_tick[c]++;
                    if ((per_m[c] != 0) && ((k_tick[c] % per_m[c]) == 0))
                        exp_ch[c] = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk_i);
        if (model_ok) begin
            n_checks++;
            if (tp_o !== exp_tp) begin
                n_fail++;
                $display("FAIL model_tp: got %0b expected %0b at t=%0t", tp_o, exp_tp, $time);
            end
            n_checks++;
            if (ch_tp_o !== exp_ch) begin
                n_fail++;
                $display("FAIL model_ch: got %b expected %b at t=%0t", ch_tp_o, exp_ch, $time);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic go(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        cyc   = 0;
    endtask

    task automatic write(input int ch, input int data);
        wr_i      = 1'b1;
        wr_ch_i   = CH_W'(ch);
        wr_data_i = DIV_W'(data);
        step();
        wr_i = 1'b0;
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();
        chk("reset_tp", 32'(tp_o), 32'd0);
        chk("reset_ch", 32'(ch_tp_o), 32'd0);

        // Free-running tick with every channel disabled.
        repeat (31) begin
            step();
            chk("s1_tp", 32'(tp_o), 32'((cyc == 10) || (cyc == 20) || (cyc == 30)));
            chk("s1_ch", 32'(ch_tp_o), 32'd0);
        end

        do_reset();
        go(1);
        write(0, 1);
        write(1, 3);
        go(10);  chk("s2_tp10", 32'(tp_o), 32'd1); chk("s2_ch10", 32'(ch_tp_o), 32'b00001);
        go(20);  chk("s2_tp20", 32'(tp_o), 32'd1); chk("s2_ch20", 32'(ch_tp_o), 32'b00001);

        go(24);
        sync_i = 1'b1;
        step();
        sync_i = 1'b0;
        write(2, 2);
        go(30);  chk("s3_tp30", 32'(tp_o), 32'd0); chk("s3_ch30", 32'(ch_tp_o), 32'd0);
        go(35);  chk("s3_tp35", 32'(tp_o), 32'd1); chk("s3_ch35", 32'(ch_tp_o), 32'b00001);
        go(45);  chk("s3_ch45", 32'(ch_tp_o), 32'b00101);
        go(55);  chk("s3_ch55", 32'(ch_tp_o), 32'b00011);

        // Rewrite ch2 exactly on the tick its pulse was due.
        go(64);
        write(2, 2);
        chk("s4_tp65", 32'(tp_o), 32'd1);
        chk("s4_ch65", 32'(ch_tp_o), 32'b00001);
        go(75);  chk("s4_ch75", 32'(ch_tp_o), 32'b00001);
        go(85);  chk("s4_ch85", 32'(ch_tp_o), 32'b00111);

        write(5, 7);
        go(95);  chk("s5_ch95", 32'(ch_tp_o), 32'b00001);
        go(105); chk("s5_ch105", 32'(ch_tp_o), 32'b00101);
        go(115); chk("s5_ch115", 32'(ch_tp_o), 32'b00011);

        go(136);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("s6_tp137", 32'(tp_o), 32'd0);
        chk("s6_ch137", 32'(ch_tp_o), 32'd0);
        go(146); chk("s6_tp146", 32'(tp_o), 32'd0);
        go(147); chk("s6_tp147", 32'(tp_o), 32'd1); chk("s6_ch147", 32'(ch_tp_o), 32'd0);

        repeat (3000) begin
            rst_i     = ($urandom_range(0, 399) == 0);
            sync_i    = ($urandom_range(0, 49) == 0);
            wr_i      = ($urandom_range(0, 4) == 0);
            wr_ch_i   = CH_W'($urandom_range(0, 7));
            wr_data_i = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 65535))
                                                    : DIV_W'($urandom_range(0, 4));
            step();
        end
        rst_i  = 1'b0;
        sync_i = 1'b0;
        wr_i   = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
